seg_scan_ctrl: RTL and testbench

//   Time-multiplexes a 16-bit hex value onto the board's 4-digit common-anode

---
 rtl/seg_scan_ctrl.sv | 147 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode seven-segment scanner. Shadows the display data on load and rotates
// through the digits with a blanking guard at the start of each slot.
module seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    input  logic        lzs_en,
    input  logic        load,
    output logic [7:0]  seg_cat,
    output logic [3:0]  seg_an,
    output logic        frame_done
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntMax   = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW:0]   BlankLim = (CntW + 1)'(BLANK_CYC);

    typedef enum logic {StBlank, StShow} state_e;

    logic [15:0]     val_q;
    logic [3:0]      dp_q;
    logic [3:0]      en_q;
    logic            lzs_q;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    state_e          state_q, state_d;
    logic            cnt_wrap;

    logic [3:0]      supp;
    logic [3:0]      nib;
    logic            lit;
    logic [3:0]      an_d;
    logic [7:0]      cat_d;
    logic            frame_d;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h27;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Shadow registers: the display only ever sees data captured by a load strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= 16'h0000;
            dp_q  <= 4'h0;
            en_q  <= 4'h0;
            lzs_q <= 1'b0;
        end else if (load) begin
            val_q <= value;
            dp_q  <= dp_in;
            en_q  <= digit_en;
            lzs_q <= lzs_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            state_q <= StBlank;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
        end
    end

    // The FSM state is derived from the counter value it will sit alongside next cycle.
    always_comb begin
        cnt_wrap = (cnt_q == CntMax);
        cnt_d    = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d    = cnt_wrap ? idx_q + 2'd1 : idx_q;
        frame_d  = cnt_wrap && (idx_q == 2'd3);
        state_d  = StShow;
        case (state_q)
            StBlank: if ({1'b0, cnt_d} < BlankLim) state_d = StBlank;
            StShow:  if ({1'b0, cnt_d} < BlankLim) state_d = StBlank;
            default: state_d = StBlank;
        endcase
    end

    // Leading-zero suppression looks at raw nibbles, independent of the enables.
    always_comb begin
        supp    = 4'b0000;
        supp[3] = lzs_q && (val_q[15:12] == 4'h0);
        supp[2] = lzs_q && (val_q[15:8] == 8'h00);
        supp[1] = lzs_q && (val_q[15:4] == 12'h000);
    end

    always_comb begin
        nib = 4'h0;
        unique case (idx_q)
            2'd0: nib = val_q[3:0];
            2'd1: nib = val_q[7:4];
            2'd2: nib = val_q[11:8];
            2'd3: nib = val_q[15:12];
            default: nib = 4'h0;
        endcase
    end

    always_comb begin
        an_d  = 4'hF;
        cat_d = 8'hFF;
        lit   = (state_q == StShow) && en_q[idx_q] && !supp[idx_q];
        if (lit) begin
            an_d  = ~(4'b0001 << idx_q);
            cat_d = {~dp_q[idx_q], hex_to_seg(nib)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_an     <= 4'hF;
            seg_cat    <= 8'hFF;
            frame_done <= 1'b0;
        end else begin
            seg_an     <= an_d;
            seg_cat    <= cat_d;
            frame_done <= frame_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a slot-timing model queues the expected pins every edge; two
// instances cover blanking on (2 cycles) and off.
module tb_seg_scan_ctrl;

    localparam int unsigned Div   = 8;
    localparam int unsigned Blank = 2;
    localparam logic [12:0] Dark  = {4'hF, 8'hFF, 1'b0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  digit_en = 4'h0;
    logic        lzs_en = 1'b0;
    logic        load = 1'b0;

    logic [7:0]  cat_a, cat_b;
    logic [3:0]  an_a, an_b;
    logic        fd_a, fd_b;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.REFRESH_DIV(Div), .BLANK_CYC(Blank)) dut_a (
        .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .digit_en(digit_en),
        .lzs_en(lzs_en), .load(load), .seg_cat(cat_a), .seg_an(an_a), .frame_done(fd_a)
    );

    seg_scan_ctrl #(.REFRESH_DIV(Div), .BLANK_CYC(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .digit_en(digit_en),
        .lzs_en(lzs_en), .load(load), .seg_cat(cat_b), .seg_an(an_b), .frame_done(fd_b)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned k = 0;
    string       phase = "reset";

    logic [15:0] sh_val = 16'h0;
    logic [3:0]  sh_dp = 4'h0;
    logic [3:0]  sh_en = 4'h0;
    logic        sh_lzs = 1'b0;

    logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E};
    logic [12:0] q_a [$];
    logic [12:0] q_b [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Pins visible after the kk-th edge since reset release reflect slot position kk-1.
    function automatic logic [12:0] model(input int unsigned kk, input int unsigned blank);
        int unsigned c, i;
        logic        lit, nz;
        logic [3:0]  nib, an;
        logic [7:0]  cat;
        logic        fd;
        if (kk == 0) return Dark;
        c   = (kk - 1) % Div;
        i   = ((kk - 1) / Div) % 4;
        lit = (c >= blank) && sh_en[i];
        if (sh_lzs && i > 0) begin
            nz = 1'b0;
            for (int unsigned j = i; j < 4; j++) if (sh_val[j*4 +: 4] != 4'h0) nz = 1'b1;
            if (!nz) lit = 1'b0;
        end
        nib = sh_val[i*4 +: 4];
        an  = 4'hF;
        cat = 8'hFF;
        if (lit) begin
            an     = 4'hF;
            an[i]  = 1'b0;
            cat    = {~sh_dp[i], seg_tab[nib][6:0]};
        end
        fd = ((kk % (4 * Div)) == 0);
        return {an, cat, fd};
    endfunction

    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            k = 0;
            q_a.push_back(Dark);
            q_b.push_back(Dark);
        end else begin
            k++;
            q_a.push_back(model(k, Blank));
            q_b.push_back(model(k, 0));
            if (load) begin
                sh_val = value;
                sh_dp  = dp_in;
                sh_en  = digit_en;
                sh_lzs = lzs_en;
            end
        end
        #1;
        check({phase, "_a"}, {19'h0, an_a, cat_a, fd_a}, {19'h0, q_a.pop_front()});
        check({phase, "_b"}, {19'h0, an_b, cat_b, fd_b}, {19'h0, q_b.pop_front()});
    endtask

    task automatic run(input int unsigned n);
        repeat (n) step();
    endtask

    // Inputs are scrambled after the strobe; the shadow must ignore them.
    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en,
                           input logic lzs);
        value    = v;
        dp_in    = dp;
        digit_en = en;
        lzs_en   = lzs;
        load     = 1'b1;
        step();
        load     = 1'b0;
        value    = 16'($urandom);
        dp_in    = 4'($urandom);
        digit_en = 4'($urandom);
        lzs_en   = 1'($urandom);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        run(5);
        rst_n = 1'b1;

        phase = "no_load";
        run(40);

        phase = "h1234";
        do_load(16'h1234, 4'h0, 4'hF, 1'b0);
        run(70);

        phase = "lzs_0050";
        do_load(16'h0050, 4'h0, 4'hF, 1'b1);
        run(40);
        phase = "nolzs_0050";
        do_load(16'h0050, 4'h0, 4'hF, 1'b0);
        run(40);

        phase = "lzs_0000";
        do_load(16'h0000, 4'h0, 4'hF, 1'b1);
        run(40);
        phase = "dp_8888";
        do_load(16'h8888, 4'b0100, 4'hF, 1'b0);
        run(40);
        phase = "en_1010";
        do_load(16'h8888, 4'b0100, 4'b1010, 1'b0);
        run(40);
        phase = "lzs_en_off";
        do_load(16'h0300, 4'h0, 4'b0011, 1'b1);
        run(40);

        phase = "back2back";
        value = 16'hABCD; dp_in = 4'hF; digit_en = 4'hF; lzs_en = 1'b0; load = 1'b1;
        step();
        do_load(16'h9E0F, 4'b1001, 4'hF, 1'b0);
        run(40);

        // Mid-slot load on digit 1: old pattern for one more edge, new one on the second.
        phase = "midslot";
        do_load(16'h0010, 4'h0, 4'hF, 1'b0);
        for (int n = 0; n < 40 && (k % (4 * Div)) != (Div + 4); n++) step();
        check("midslot_pos", k % (4 * Div), Div + 4);
        do_load(16'h0070, 4'h0, 4'hF, 1'b0);
        check("midslot_old", {an_a, cat_a}, {4'hD, 8'hF9});
        step();
        check("midslot_new", {an_a, cat_a}, {4'hD, 8'hF8});
        run(40);

        // Asynchronous reset between edges must darken the pins without a clock edge.
        phase = "async_rst";
        #2;
        rst_n  = 1'b0;
        sh_val = 16'h0; sh_dp = 4'h0; sh_en = 4'h0; sh_lzs = 1'b0;
        #1;
        check("async_rst_a", {19'h0, an_a, cat_a, fd_a}, {19'h0, Dark});
        check("async_rst_b", {19'h0, an_b, cat_b, fd_b}, {19'h0, Dark});
        run(3);
        rst_n = 1'b1;
        phase = "post_rst";
        run(40);
        phase = "reload";
        do_load(16'hC5A2, 4'b0010, 4'hF, 1'b1);
        run(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
